// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer carrying one payload bundle over a valid/ready
// handshake. It has a synchronous flush and an optional two-entry skid mode.
// With SKID=1, in_ready comes straight from a flop, so the upstream stage
// never sees a combinational path from the downstream out_ready.
module pipe_stage_buf #(
  parameter int DATA_WIDTH      = 32,
  parameter int SKID            = 1,
  parameter int CLEAR_ON_BUBBLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] main_q;
  logic                  accept;
  logic                  deliver;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  generate
    if (SKID == 0) begin : g_single
      logic                  valid_q;
      logic                  valid_d;
      logic [DATA_WIDTH-1:0] main_d;

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign occupancy = {1'b0, valid_q};

      // Next state of the single register. A flush empties the buffer and
      // leaves the payload alone, so a flushed beat is never loaded.
      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (accept) begin
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (deliver) begin
          valid_d = 1'b0;
        end
      end

      // Register update. Reset takes priority over flush and any handshake.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end
    end else begin : g_skid
      state_e                state_q;
      state_e                state_d;
      logic                  ready_q;
      logic                  ready_d;
      logic [DATA_WIDTH-1:0] main_d;
      logic [DATA_WIDTH-1:0] skid_q;
      logic [DATA_WIDTH-1:0] skid_d;

      assign in_ready  = ready_q;
      assign out_valid = (state_q != EMPTY);
      assign occupancy = state_q;

      // Occupancy FSM. The main register always holds the oldest beat and
      // the skid register holds the second one. in_ready is computed one
      // cycle early from the next state, so it can be registered.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (accept && deliver) begin
              main_d = in_data;
            end else if (accept) begin
              state_d = FULL;
              skid_d  = in_data;
            end else if (deliver) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (deliver) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
        if (flush) begin
          state_d = EMPTY;
          main_d  = main_q;
          skid_d  = skid_q;
        end
        ready_d = (state_d != FULL);
      end

      // State, payload and in_ready registers. Reset takes priority over
      // flush and any handshake.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          ready_q <= ready_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end
    end
  endgenerate

  generate
    if (CLEAR_ON_BUBBLE != 0) begin : g_clear
      assign out_data = out_valid ? main_q : '0;
    end else begin : g_hold
      assign out_data = main_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and scoreboard bench for pipe_stage_buf. Instance A uses the
// skid configuration and instance B uses the single-register configuration.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        aRst, aFlush, aInValid, aInReady, aOutValid, aOutReady;
  logic [31:0] aInData, aOutData;
  logic [1:0]  aOcc;
  logic        bRst, bFlush, bInValid, bInReady, bOutValid, bOutReady;
  logic [31:0] bInData, bOutData;
  logic [1:0]  bOcc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_WIDTH(32), .SKID(1), .CLEAR_ON_BUBBLE(1)) dutSkid (
    .clk(clk), .rst(aRst), .flush(aFlush),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .occupancy(aOcc)
  );

  pipe_stage_buf #(.DATA_WIDTH(32), .SKID(0), .CLEAR_ON_BUBBLE(1)) dutSingle (
    .clk(clk), .rst(bRst), .flush(bFlush),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .occupancy(bOcc)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aRst = 1; aFlush = 0; aInValid = 0; aInData = 0; aOutReady = 0;
    bRst = 1; bFlush = 0; bInValid = 0; bInData = 0; bOutReady = 0;
    tick(); tick();
    aRst = 0; bRst = 0; #1;
    compared++; if (aOutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_a_valid got %b exp 0", aOutValid); end
    compared++; if (aOutData !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_a_data got %h exp 0", aOutData); end
    compared++; if (aOcc !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_a_occ got %0d exp 0", aOcc); end
    compared++; if (aInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_a_ready got %b exp 1", aInReady); end
    compared++; if (bOutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_b_valid got %b exp 0", bOutValid); end
    compared++; if (bInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_b_ready got %b exp 1", bInReady); end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    aInValid = 1; aOutReady = 1;
    for (int i = 0; i < 3; i++) begin
      aInData = vals[i];
      tick();
      compared++; if (aOutValid !== 1'b1 || aOutData !== vals[i]) begin mismatched++; $display("[TB] FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, aOutValid, aOutData, vals[i]); end
      compared++; if (aOcc !== 2'd1 || aInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_occ_%0d got occ=%0d rdy=%b exp occ=1 rdy=1", i, aOcc, aInReady); end
    end
    aInValid = 0;
    tick();
    compared++; if (aOutValid !== 1'b0 || aOutData !== 32'h0) begin mismatched++; $display("[TB] FAIL stream_drain got v=%b d=%h exp v=0 d=0", aOutValid, aOutData); end
  endtask

  task automatic test_backpressure();
    aOutReady = 0; aInValid = 1; aInData = 32'hA;
    tick();
    compared++; if (aOcc !== 2'd1 || aInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_one got occ=%0d rdy=%b exp occ=1 rdy=1", aOcc, aInReady); end
    aInData = 32'hB;
    tick();
    compared++; if (aOcc !== 2'd2 || aInReady !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", aOcc, aInReady); end
    aInData = 32'hC;
    tick();
    compared++; if (aOcc !== 2'd2 || aOutData !== 32'hA) begin mismatched++; $display("[TB] FAIL bp_hold got occ=%0d d=%h exp occ=2 d=a", aOcc, aOutData); end
    aOutReady = 1; #1;
    compared++; if (aInReady !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready_registered got %b exp 0", aInReady); end
    tick();
    compared++; if (aOutData !== 32'hB || aOcc !== 2'd1 || aInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_rel_b got d=%h occ=%0d rdy=%b exp d=b occ=1 rdy=1", aOutData, aOcc, aInReady); end
    tick();
    compared++; if (aOutData !== 32'hC || aOcc !== 2'd1) begin mismatched++; $display("[TB] FAIL bp_rel_c got d=%h occ=%0d exp d=c occ=1", aOutData, aOcc); end
    aInValid = 0;
    tick();
    compared++; if (aOutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_empty got %b exp 0", aOutValid); end
  endtask

  task automatic test_flush();
    aOutReady = 0; aInValid = 1; aInData = 32'hA; tick();
    aInData = 32'hB; tick();
    compared++; if (aOcc !== 2'd2) begin mismatched++; $display("[TB] FAIL flush_fill got occ=%0d exp 2", aOcc); end
    aFlush = 1; aInData = 32'hD;
    tick();
    compared++; if (aOutValid !== 1'b0 || aOcc !== 2'd0 || aOutData !== 32'h0 || aInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_empty got v=%b occ=%0d d=%h rdy=%b exp v=0 occ=0 d=0 rdy=1", aOutValid, aOcc, aOutData, aInReady); end
    aFlush = 0; aInValid = 0; aOutReady = 1;
    tick(); tick();
    compared++; if (aOutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_d got v=%b d=%h exp v=0", aOutValid, aOutData); end
  endtask

  task automatic test_reset_mid();
    aOutReady = 0; aInValid = 1; aInData = 32'hA; tick();
    aInData = 32'hB; tick();
    aRst = 1; aFlush = 1; aInData = 32'hE;
    tick();
    compared++; if (aOutValid !== 1'b0 || aOcc !== 2'd0 || aOutData !== 32'h0 || aInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid got v=%b occ=%0d d=%h rdy=%b exp v=0 occ=0 d=0 rdy=1", aOutValid, aOcc, aOutData, aInReady); end
    aRst = 0; aFlush = 0; aInData = 32'h55;
    tick();
    compared++; if (aOutValid !== 1'b1 || aOutData !== 32'h55 || aOcc !== 2'd1) begin mismatched++; $display("[TB] FAIL rstmid_first got v=%b d=%h occ=%0d exp v=1 d=55 occ=1", aOutValid, aOutData, aOcc); end
    aInValid = 0; aOutReady = 1;
    tick();
  endtask

  task automatic test_noskid();
    bOutReady = 0; bInValid = 1; bInData = 32'h5;
    tick();
    compared++; if (bInReady !== 1'b0 || bOutData !== 32'h5) begin mismatched++; $display("[TB] FAIL ns_stall got rdy=%b d=%h exp rdy=0 d=5", bInReady, bOutData); end
    bInData = 32'h6;
    tick();
    compared++; if (bOutData !== 32'h5 || bOcc !== 2'd1) begin mismatched++; $display("[TB] FAIL ns_hold got d=%h occ=%0d exp d=5 occ=1", bOutData, bOcc); end
    bInValid = 0; bOutReady = 1; #1;
    compared++; if (bInReady !== 1'b1) begin mismatched++; $display("[TB] FAIL ns_comb_ready got %b exp 1", bInReady); end
    tick();
    compared++; if (bOutValid !== 1'b0 || bOutData !== 32'h0) begin mismatched++; $display("[TB] FAIL ns_bubble got v=%b d=%h exp v=0 d=0", bOutValid, bOutData); end
    bInValid = 1; bInData = 32'h7; tick();
    bInData = 32'h8; tick();
    compared++; if (bOutData !== 32'h8 || bOutValid !== 1'b1) begin mismatched++; $display("[TB] FAIL ns_b2b got v=%b d=%h exp v=1 d=8", bOutValid, bOutData); end
    bFlush = 1; bInData = 32'h9; tick();
    compared++; if (bOutValid !== 1'b0 || bOcc !== 2'd0) begin mismatched++; $display("[TB] FAIL ns_flush got v=%b occ=%0d exp v=0 occ=0", bOutValid, bOcc); end
    bFlush = 0; bInValid = 0;
  endtask

  // Random valid/ready/flush on both instances against queue models.
  task automatic test_random();
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] expA, expB;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      aInValid = ($urandom_range(0, 3) != 0); aOutReady = ($urandom_range(0, 2) != 0);
      aInData = $urandom(); aFlush = ($urandom_range(0, 63) == 0);
      bInValid = ($urandom_range(0, 3) != 0); bOutReady = ($urandom_range(0, 2) != 0);
      bInData = $urandom(); bFlush = ($urandom_range(0, 63) == 0);
      #1;
      compared++; if (aOcc !== 2'(qa.size()) || aInReady !== (qa.size() != 2)) begin mismatched++; $display("[TB] FAIL rand_a_state cyc %0d got occ=%0d rdy=%b exp occ=%0d", cyc, aOcc, aInReady, qa.size()); end
      compared++; if (bOcc !== 2'(qb.size()) || bInReady !== (qb.size() == 0 || bOutReady)) begin mismatched++; $display("[TB] FAIL rand_b_state cyc %0d got occ=%0d rdy=%b exp occ=%0d", cyc, bOcc, bInReady, qb.size()); end
      if (aOutValid && aOutReady && qa.size() > 0) begin
        expA = qa.pop_front();
        compared++; if (aOutData !== expA) begin mismatched++; $display("[TB] FAIL rand_a_data cyc %0d got %h exp %h", cyc, aOutData, expA); end
      end
      if (bOutValid && bOutReady && qb.size() > 0) begin
        expB = qb.pop_front();
        compared++; if (bOutData !== expB) begin mismatched++; $display("[TB] FAIL rand_b_data cyc %0d got %h exp %h", cyc, bOutData, expB); end
      end
      if (aFlush) qa.delete(); else if (aInValid && aInReady) qa.push_back(aInData);
      if (bFlush) qb.delete(); else if (bInValid && bInReady) qb.push_back(bInData);
      @(posedge clk); #1;
    end
    aInValid = 0; aFlush = 0; bInValid = 0; bFlush = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_noskid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
